// File: rtl/clock_divider_ctrl.sv
// Purpose     : run-time controller for a power-of-two clock prescaler (clk / 2^k, k = 1..STAGES),
//               single synchronous counter, no derived clocks; 50% level output plus tick enable.
// Latency     : cfg accepted in IDLE -> first tick 2^k cycles later; ratio changes land on a period boundary.
// Backpressure: o_cfg_ready drops while a change is pending (PEND) and returns when it is applied.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_cfg_valid  host config request valid
//   o_cfg_ready  controller can accept config (transfer = valid & ready)
//   i_cfg_div    requested exponent k
//   i_cfg_run    1 = run divider, 0 = stop after current period
//   o_cfg_err    one-cycle pulse: accepted config had illegal k and was discarded
//   o_div_out    divided level, period 2^k cycles, 50% duty
//   o_tick       one-cycle pulse in the last cycle of each period
//   o_active     high while running or holding a pending change
//   o_cur_div    exponent currently applied
module clock_divider_ctrl #(
  parameter  int STAGES    = 5,
  parameter  int RESET_DIV = 5,
  localparam int DIVW      = $clog2(STAGES + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_cfg_valid,
  output logic            o_cfg_ready,
  input  logic [DIVW-1:0] i_cfg_div,
  input  logic            i_cfg_run,
  output logic            o_cfg_err,
  output logic            o_div_out,
  output logic            o_tick,
  output logic            o_active,
  output logic [DIVW-1:0] o_cur_div
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [STAGES-1:0]   r_cnt;
  logic [DIVW-1:0]     r_cur_div;
  logic [DIVW-1:0]     r_pend_div;
  logic                r_pend_run;
  logic                r_cfg_err;

  logic                w_cfg_ready;
  logic                w_accept;
  logic                w_legal;
  logic                w_good;
  logic [STAGES-1:0]   w_mask;
  logic                w_boundary;
  logic [DIVW-1:0]     w_idx;

  assign w_cfg_ready = (r_state != S_PEND);
  assign w_accept    = i_cfg_valid & w_cfg_ready;
  assign w_legal     = (i_cfg_div != '0) && (i_cfg_div <= DIVW'(STAGES));
  assign w_good      = w_accept & w_legal;

  // Terminal count for the current ratio: low cur_div bits set.
  assign w_mask      = ~({STAGES{1'b1}} << r_cur_div);
  assign w_boundary  = (r_state != S_IDLE) && (r_cnt == w_mask);
  assign w_idx       = r_cur_div - DIVW'(1);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_good && i_cfg_run) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_good) begin
          // A request arriving in the tick cycle is applied right away;
          // anything earlier waits so the current period completes.
          if (w_boundary) begin
            w_state_nxt = i_cfg_run ? S_RUN : S_IDLE;
          end else begin
            w_state_nxt = S_PEND;
          end
        end
      end
      S_PEND: begin
        if (w_boundary) begin
          w_state_nxt = r_pend_run ? S_RUN : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counter, applied ratio, pending request and error pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_cur_div  <= DIVW'(RESET_DIV);
      r_pend_div <= '0;
      r_pend_run <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= w_accept & ~w_legal;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_good) begin
            r_cur_div <= i_cfg_div;
          end
        end
        S_RUN: begin
          // Wrapping at the boundary also restarts the phase for a new ratio.
          r_cnt <= w_boundary ? '0 : r_cnt + STAGES'(1);
          if (w_good) begin
            if (w_boundary) begin
              if (i_cfg_run) begin
                r_cur_div <= i_cfg_div;
              end
            end else begin
              r_pend_div <= i_cfg_div;
              r_pend_run <= i_cfg_run;
            end
          end
        end
        S_PEND: begin
          r_cnt <= w_boundary ? '0 : r_cnt + STAGES'(1);
          if (w_boundary) begin
            if (r_pend_run) begin
              r_cur_div <= r_pend_div;
            end
            r_pend_div <= '0;
            r_pend_run <= 1'b0;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs, decoded from registered state only
  always_comb begin
    o_cfg_ready = w_cfg_ready;
    o_active    = (r_state != S_IDLE);
    o_tick      = w_boundary;
    o_div_out   = (r_state != S_IDLE) && r_cnt[w_idx];
    o_cur_div   = r_cur_div;
    o_cfg_err   = r_cfg_err;
  end

endmodule
